// File: rtl/welford_stats_stream.sv
// Multi-channel streaming Welford mean/variance accumulator. One shared
// subtract/multiply datapath walks the channels serially per sample and per readout.

module welford_inv_lut #(
  parameter int FRAC_BITS = 16,
  parameter int MAX_N     = 1024,
  parameter int NW        = 11
) (
  input  logic [NW-1:0]      n,
  output logic [FRAC_BITS:0] inv
);
  logic [FRAC_BITS:0] lut [2**NW];

  // inv(0) and out-of-range counts read as zero, which also makes M2/(N-1) vanish at N==1
  for (genvar i = 0; i < 2**NW; i++) begin : g_lut
    if (i == 0 || i > MAX_N) begin : g_z
      assign lut[i] = '0;
    end else begin : g_v
      assign lut[i] = (FRAC_BITS+1)'((64'd1 << FRAC_BITS) / 64'(i));
    end
  end

  assign inv = lut[n];
endmodule

module welford_stats_stream #(
  parameter int INT_BITS    = 15,
  parameter int FRAC_BITS   = 16,
  parameter int NUM_CH      = 8,
  parameter int MAX_SAMPLES = 1024,
  parameter int COUNT_WIDTH = $clog2(MAX_SAMPLES) + 1,
  localparam int VW  = 1 + INT_BITS + FRAC_BITS,
  localparam int CHW = $clog2(NUM_CH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [NUM_CH*VW-1:0]   s_data,
  input  logic                   rd_req,
  input  logic                   rd_mode,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [CHW-1:0]         m_ch,
  output logic [VW-1:0]          m_mean,
  output logic [2*VW-1:0]        m_var,
  output logic                   m_last,
  output logic [COUNT_WIDTH-1:0] sample_count,
  output logic                   saturated,
  output logic                   busy
);
  localparam int IXW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW  = 3*VW + 1;

  typedef enum logic [1:0] {IDLE, UPD_MEAN, UPD_M2, READ} state_t;
  state_t state, state_nx;

  logic [CHW-1:0]         ch;
  logic [IXW-1:0]         ix;
  logic [COUNT_WIDTH-1:0] n_cnt, lut_n;
  logic [FRAC_BITS:0]     inv;
  logic                   rd_mode_r;

  logic [NUM_CH-1:0][VW-1:0]   x_reg, mean_r;
  logic [NUM_CH-1:0][VW:0]     delta_r;
  logic [NUM_CH-1:0][2*VW-1:0] m2_r;

  logic signed [VW-1:0]   x_cur, mu_cur, mean_upd;
  logic signed [VW:0]     diff, dl_cur;
  logic signed [2*VW-1:0] m2_cur, m2_upd, var_res;
  logic signed [PW-1:0]   op_a, op_b, prod;
  logic                   s_hs, at_max, last_ch, rd_go;

  assign s_ready = (state == IDLE) && !clear;
  assign busy    = (state != IDLE);
  assign s_hs    = s_valid && s_ready;
  assign at_max  = (n_cnt == COUNT_WIDTH'(MAX_SAMPLES));
  assign rd_go   = rd_req && (n_cnt != '0);
  assign last_ch = (ch == CHW'(NUM_CH - 1));
  assign sample_count = n_cnt;

  assign ix     = IXW'(ch);
  assign x_cur  = x_reg[ix];
  assign mu_cur = mean_r[ix];
  assign dl_cur = delta_r[ix];
  assign m2_cur = m2_r[ix];
  // In UPD_M2 mean_r already holds the updated mean, so diff is x - mean_new
  assign diff   = {x_cur[VW-1], x_cur} - {mu_cur[VW-1], mu_cur};
  assign lut_n  = (state == READ && rd_mode_r) ? n_cnt - COUNT_WIDTH'(1) : n_cnt;

  welford_inv_lut #(
    .FRAC_BITS(FRAC_BITS),
    .MAX_N    (MAX_SAMPLES),
    .NW       (COUNT_WIDTH)
  ) u_inv (
    .n  (lut_n),
    .inv(inv)
  );

  always_comb begin
    op_a = {{(PW-VW-1){diff[VW]}}, diff};
    op_b = {{(PW-FRAC_BITS-1){1'b0}}, inv};
    case (state)
      UPD_M2: begin
        op_a = {{(PW-VW-1){dl_cur[VW]}}, dl_cur};
        op_b = {{(PW-VW-1){diff[VW]}}, diff};
      end
      READ:    op_a = {{(PW-2*VW){m2_cur[2*VW-1]}}, m2_cur};
      default: ;
    endcase
  end

  assign prod     = op_a * op_b;
  assign mean_upd = mu_cur + VW'(prod >>> FRAC_BITS);
  assign m2_upd   = m2_cur + (2*VW)'(prod >>> FRAC_BITS);
  assign var_res  = (2*VW)'(prod >>> FRAC_BITS);

  always_comb begin
    state_nx = state;
    if (clear) state_nx = IDLE;
    else begin
      case (state)
        IDLE: begin
          if (s_hs) begin
            if (!at_max) state_nx = UPD_MEAN;
          end else if (rd_go) state_nx = READ;
        end
        UPD_MEAN: if (last_ch) state_nx = UPD_M2;
        UPD_M2:   if (last_ch) state_nx = IDLE;
        READ:     if (m_valid && m_ready && m_last) state_nx = IDLE;
        default:  state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch        <= '0;
      n_cnt     <= '0;
      saturated <= 1'b0;
      rd_mode_r <= 1'b0;
      x_reg     <= '0;
      mean_r    <= '0;
      delta_r   <= '0;
      m2_r      <= '0;
      m_valid   <= 1'b0;
      m_ch      <= '0;
      m_mean    <= '0;
      m_var     <= '0;
      m_last    <= 1'b0;
    end else if (clear) begin
      ch        <= '0;
      n_cnt     <= '0;
      saturated <= 1'b0;
      mean_r    <= '0;
      m2_r      <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_hs) begin
            if (at_max) saturated <= 1'b1;
            else begin
              x_reg <= s_data;
              n_cnt <= n_cnt + COUNT_WIDTH'(1);
              ch    <= '0;
            end
          end else if (rd_go) begin
            rd_mode_r <= rd_mode;
            ch        <= '0;
          end
        end
        UPD_MEAN: begin
          mean_r[ix]  <= mean_upd;
          delta_r[ix] <= diff;
          ch          <= last_ch ? '0 : ch + CHW'(1);
        end
        UPD_M2: begin
          m2_r[ix] <= m2_upd;
          ch       <= last_ch ? '0 : ch + CHW'(1);
        end
        READ: begin
          // ch names the next beat to load; m_* only move on an empty slot or a handshake
          if (!m_valid || (m_ready && !m_last)) begin
            m_valid <= 1'b1;
            m_ch    <= ch;
            m_mean  <= mu_cur;
            m_var   <= var_res;
            m_last  <= last_ch;
            ch      <= ch + CHW'(1);
          end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            ch      <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_welford_stats_stream.sv
// Directed bench for welford_stats_stream: two instances (deep and shallow count limit)
// share all inputs; use_b selects which one is observed.

module tb_welford_stats_stream;
  localparam int NCH = 4;
  localparam int VW  = 32;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, s_valid = 1'b0;
  logic rd_req = 1'b0, rd_mode = 1'b0, m_ready = 1'b1;
  logic [NCH*VW-1:0] s_data = '0;

  logic        a_s_ready, a_m_valid, a_m_last, a_sat, a_busy;
  logic [2:0]  a_m_ch;
  logic [31:0] a_m_mean;
  logic [63:0] a_m_var;
  logic [10:0] a_cnt;
  logic        b_s_ready, b_m_valid, b_m_last, b_sat, b_busy;
  logic [2:0]  b_m_ch;
  logic [31:0] b_m_mean;
  logic [63:0] b_m_var;
  logic [2:0]  b_cnt;

  bit use_b = 1'b0;
  logic        o_valid, o_last, o_sat, o_busy, o_sready;
  logic [2:0]  o_ch;
  logic [31:0] o_mean;
  logic [63:0] o_var;
  logic [10:0] o_cnt;

  int n_pass = 0, n_total = 0;

  welford_stats_stream #(.NUM_CH(NCH), .MAX_SAMPLES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(a_s_ready),
    .s_data(s_data), .rd_req(rd_req), .rd_mode(rd_mode), .m_valid(a_m_valid),
    .m_ready(m_ready), .m_ch(a_m_ch), .m_mean(a_m_mean), .m_var(a_m_var),
    .m_last(a_m_last), .sample_count(a_cnt), .saturated(a_sat), .busy(a_busy));

  welford_stats_stream #(.NUM_CH(NCH), .MAX_SAMPLES(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(b_s_ready),
    .s_data(s_data), .rd_req(rd_req), .rd_mode(rd_mode), .m_valid(b_m_valid),
    .m_ready(m_ready), .m_ch(b_m_ch), .m_mean(b_m_mean), .m_var(b_m_var),
    .m_last(b_m_last), .sample_count(b_cnt), .saturated(b_sat), .busy(b_busy));

  assign o_valid  = use_b ? b_m_valid : a_m_valid;
  assign o_last   = use_b ? b_m_last  : a_m_last;
  assign o_sat    = use_b ? b_sat     : a_sat;
  assign o_busy   = use_b ? b_busy    : a_busy;
  assign o_sready = use_b ? b_s_ready : a_s_ready;
  assign o_ch     = use_b ? b_m_ch    : a_m_ch;
  assign o_mean   = use_b ? b_m_mean  : a_m_mean;
  assign o_var    = use_b ? b_m_var   : a_m_var;
  assign o_cnt    = use_b ? {8'b0, b_cnt} : a_cnt;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int      nsamp;
    int      b1;
    int      b2;
    int      step;
    bit      mode;
    int      mbase;
    int      mstep;
    longint  vexp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [NCH*VW-1:0] mk(input int base, input int step);
    logic [NCH*VW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*VW +: VW] = 32'(base + k*step);
    return r;
  endfunction

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic push(input logic [NCH*VW-1:0] d, input bit chk_lat);
    int t, lo;
    @(negedge clk); s_data = d; s_valid = 1'b1;
    t = 0;
    while (!a_s_ready && t < 50) begin @(negedge clk); t++; end
    if (!a_s_ready) begin chk("push_ready", a_s_ready, 1'b1); s_valid = 1'b0; return; end
    @(negedge clk); s_valid = 1'b0;
    lo = 0;
    while (!a_s_ready && lo < 50) begin @(negedge clk); lo++; end
    if (chk_lat) chk("busy_cycles", lo, 8);
  endtask

  task automatic read_all(input bit mode, input int mbase, input int mstep,
                          input logic [63:0] vexp, input int bp);
    int t;
    logic [31:0] em;
    @(negedge clk); rd_mode = mode; rd_req = 1'b1;
    @(negedge clk); rd_req = 1'b0;
    chk("rd_first_cycle_valid", o_valid, 1'b0);
    for (int b = 0; b < NCH; b++) begin
      em = 32'(mbase + b*mstep);
      t = 0;
      while (!o_valid && t < 10) begin @(negedge clk); t++; end
      if (!o_valid) begin chk($sformatf("beat%0d_valid", b), o_valid, 1'b1); return; end
      if (b == bp) begin
        m_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_valid", o_valid, 1'b1);
          chk("bp_ch", o_ch, 3'(b));
          chk("bp_mean", o_mean, em);
          chk("bp_var", o_var, vexp);
        end
        m_ready = 1'b1;
      end
      chk($sformatf("beat%0d_ch", b), o_ch, 3'(b));
      chk($sformatf("beat%0d_mean", b), o_mean, em);
      chk($sformatf("beat%0d_var", b), o_var, vexp);
      chk($sformatf("beat%0d_last", b), o_last, (b == NCH-1));
      @(negedge clk);
    end
    chk("rd_end_valid", o_valid, 1'b0);
    chk("rd_end_busy", o_busy, 1'b0);
  endtask

  task automatic expect_no_beat(input string name);
    bit seen;
    @(negedge clk); rd_mode = 1'b0; rd_req = 1'b1;
    @(negedge clk); rd_req = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (o_valid || o_busy) seen = 1'b1; end
    chk(name, seen, 1'b0);
  endtask

  vec_t tbl[4];

  initial begin
    int t;
    tbl[0] = '{2, 'h20000, 'h40000, 'h10000, 1'b0, 'h30000, 'h10000, 64'h10000};
    tbl[1] = '{2, 'h20000, 'h40000, 'h10000, 1'b1, 'h30000, 'h10000, 64'h20000};
    tbl[2] = '{2, -'h10000, -'h30000, -'h10000, 1'b0, -'h20000, -'h10000, 64'h10000};
    tbl[3] = '{1, 'h18000, 0, 0, 1'b1, 'h18000, 0, 64'h0};

    repeat (3) @(negedge clk);
    chk("rst_s_ready", o_sready, 1'b1);
    chk("rst_m_var", o_var, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_m_valid", o_valid, 1'b0);
    chk("rst_count", o_cnt, 11'd0);
    chk("rst_saturated", o_sat, 1'b0);
    chk("rst_m_ch", o_ch, 3'd0);
    chk("rst_m_mean", o_mean, 32'h0);
    chk("rst_m_last", o_last, 1'b0);
    expect_no_beat("rd_empty_ignored");

    for (int i = 0; i < 4; i++) begin
      do_clear();
      push(mk(tbl[i].b1, tbl[i].step), 1'b1);
      if (tbl[i].nsamp == 2) push(mk(tbl[i].b2, tbl[i].step), 1'b1);
      chk($sformatf("vec%0d_count", i), o_cnt, 11'(tbl[i].nsamp));
      read_all(tbl[i].mode, tbl[i].mbase, tbl[i].mstep, tbl[i].vexp, -1);
    end

    // ten identical samples: mean exact, variance zero in both modes
    do_clear();
    repeat (10) push(mk('h18000, 0), 1'b0);
    chk("const10_count", o_cnt, 11'd10);
    read_all(1'b0, 'h18000, 0, 64'h0, -1);
    read_all(1'b1, 'h18000, 0, 64'h0, -1);
    chk("const10_count_after_read", o_cnt, 11'd10);

    // backpressure on beat 1
    do_clear();
    push(mk('h20000, 'h10000), 1'b0);
    push(mk('h40000, 'h10000), 1'b0);
    read_all(1'b0, 'h30000, 'h10000, 64'h10000, 1);

    // saturation on the shallow instance, then clear mid-readout
    use_b = 1'b1;
    do_clear();
    repeat (4) push(mk('h10000, 'h10000), 1'b0);
    repeat (2) push(mk('h90000, 'h10000), 1'b0);
    chk("sat_count", o_cnt, 11'd4);
    chk("sat_flag", o_sat, 1'b1);
    chk("sat_s_ready", o_sready, 1'b1);
    chk("deep_count", a_cnt, 11'd6);
    read_all(1'b1, 'h10000, 'h10000, 64'h0, -1);

    @(negedge clk); rd_mode = 1'b0; rd_req = 1'b1;
    @(negedge clk); rd_req = 1'b0;
    t = 0;
    while (!(o_valid && o_ch == 3'd2) && t < 20) begin @(negedge clk); t++; end
    chk("clr_reach_beat2", o_ch, 3'd2);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clr_m_valid", o_valid, 1'b0);
    chk("clr_count", o_cnt, 11'd0);
    chk("clr_saturated", o_sat, 1'b0);
    chk("clr_busy", o_busy, 1'b0);
    expect_no_beat("clr_rd_ignored");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/welford_stats_stream.md
Name: welford_stats_stream

Overview:
- Multi-channel streaming Welford mean/variance accumulator. It is the parametrised successor of the team's fixed-size stats accumulator.
- Takes NUM_CH signed fixed-point channels per sample through a valid/ready handshake and updates per-channel mean and M2 serially, one channel per cycle, through a shared datapath.
- On request, streams per-channel mean and variance out over a backpressured result port. Variance is either population (divide by N) or sample (divide by N-1).
- Sits between the sample front-end and downstream detection/normalisation logic.

Parameters:
- INT_BITS, 15, integer bits of input/mean (excluding sign); VW = 1+INT_BITS+FRAC_BITS.
- FRAC_BITS, 16, fractional bits; reciprocal LUT resolution.
- NUM_CH, 8, channels per sample (>=1).
- MAX_SAMPLES, 1024, count saturation limit.
- COUNT_WIDTH, $clog2(MAX_SAMPLES)+1, width of the sample counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all statistics; aborts any operation.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample ready.
- s_data  in  NUM_CH*VW  packed signed samples; channel k at [k*VW +: VW].
- rd_req  in  1  start a result readout (one-cycle pulse).
- rd_mode  in  1  0 = population variance (M2/N), 1 = sample variance (M2/(N-1)); latched with rd_req.
- m_valid  out  1  result beat valid.
- m_ready  in  1  result beat accept.
- m_ch  out  $clog2(NUM_CH)+1  channel index of the beat.
- m_mean  out  VW  signed channel mean, Q(INT.FRAC).
- m_var  out  2*VW  signed channel variance, Q(2*INT+1.FRAC).
- m_last  out  1  high on the beat for channel NUM_CH-1.
- sample_count  out  COUNT_WIDTH  samples accumulated.
- saturated  out  1  sticky flag: a sample was dropped at the limit.
- busy  out  1  high when not IDLE.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: s_ready=1, m_valid=0, m_ch=0, m_mean=0, m_var=0, m_last=0, sample_count=0, saturated=0, busy=0. All per-channel mean and M2 registers are 0.
- FSM states: IDLE, UPD_MEAN, UPD_M2, READ.
- s_ready = (state==IDLE) && !clear. rd_req is honoured only in IDLE.
- Priority in IDLE: clear > accepted sample > rd_req. An rd_req coincident with an accepted sample is ignored.
- Reciprocal inv(n): floor(2^FRAC_BITS/n) for n>=2, and exactly 2^FRAC_BITS for n=1. Sourced from the shared inverse-count LUT module. Operands are sign-extended and multiplied in full precision, then arithmetic-shifted right by FRAC_BITS (floor).
- Sample accept: on a handshake edge the sample is registered into x_reg and N increments. The FSM then goes to UPD_MEAN with ch=0.
- UPD_MEAN, one channel per cycle:
  - delta[ch] = x[ch] - mean[ch]
  - mean[ch] += (delta[ch]*inv(N)) >>> FRAC_BITS
  - delta[ch] is stored.
  - After ch = NUM_CH-1, go to UPD_M2 with ch=0.
- UPD_M2, one channel per cycle:
  - M2[ch] += (delta[ch]*(x[ch] - mean[ch])) >>> FRAC_BITS, using the updated mean.
  - After ch = NUM_CH-1, return to IDLE.
- Sample latency: 2*NUM_CH cycles of busy. s_ready returns high on the cycle after the last UPD_M2 cycle.
- Saturation: a handshake with N == MAX_SAMPLES is accepted (s_ready stays high) but the sample is discarded. No state change except saturated <= 1.
- rd_req in IDLE with N==0: ignored.
- rd_req in IDLE with N>=1: go to READ. m_valid rises on the following cycle with beat ch=0. Per beat:
  - m_mean = mean[ch].
  - Mode 0: m_var = (M2[ch]*inv(N)) >>> FRAC_BITS.
  - Mode 1 with N>=2: m_var = (M2[ch]*inv(N-1)) >>> FRAC_BITS.
  - Mode 1 with N==1: m_var = 0.
- Backpressure: while m_valid && !m_ready, all m_* outputs hold stable. Each m_valid && m_ready handshake advances ch. The beat with m_last=1 completes the readout; state returns to IDLE and m_valid drops on the next cycle.
- Statistics persist across readouts. A readout does not modify N, mean or M2.
- clear, any state: the next cycle is IDLE with mean, M2, N and saturated = 0 and m_valid = 0. A partially processed sample is discarded.

Test Plan:
1. Reset release with NUM_CH=4 -> s_ready=1, busy=0, m_valid=0, sample_count=0, saturated=0. rd_req produces no beat.
2. NUM_CH=4, two samples: channel k gets 2.0+k, then 4.0+k. rd_req mode 0 -> four beats, m_ch=0..3, m_mean=0x30000+k*0x10000, m_var=0x10000, m_last only on ch3. Mode 1 -> m_var=0x20000. s_ready low for exactly 8 cycles after each accept.
3. Negative data: channel 0 gets -1.0 then -3.0 -> m_mean=0xFFFE0000 and m_var=0x10000 in mode 0. A single constant sample 0x18000 then rd_req mode 1 -> m_mean=0x18000, m_var=0.
4. Ten identical samples 0x18000 -> mean exactly 0x18000, m_var=0 in both modes. sample_count=10.
5. Backpressure: m_ready low for 5 cycles on beat 1 -> m_valid, m_ch, m_mean, m_var held constant. All 4 beats are delivered exactly once, in order.
6. MAX_SAMPLES=4, push 6 samples -> sample_count=4, saturated=1, statistics match the first 4 samples. Then clear during READ after beat 1 -> m_valid=0 next cycle, sample_count=0, saturated=0, and the next rd_req is ignored.
